// File: rtl/ped_crossing_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : ped_crossing_scheduler_if
// Brief    : Signal bundle between crosswalk buttons/light controller and the
//            pedestrian-crossing scheduler.
// Revision : 1.0 - initial release
// ============================================================================
interface ped_crossing_scheduler_if;
    logic btn_a;
    logic btn_b;
    logic ra;
    logic ga;
    logic rb;
    logic gb;
    logic req_a;
    logic req_b;
    logic pending_a;
    logic pending_b;
    logic walk_a;
    logic walk_b;
    logic dwalk_a;
    logic dwalk_b;
    logic abort_a;
    logic abort_b;

    // Environment side: buttons and light controller
    modport master (
        output btn_a, btn_b, ra, ga, rb, gb,
        input  req_a, req_b, pending_a, pending_b, walk_a, walk_b,
               dwalk_a, dwalk_b, abort_a, abort_b
    );

    // Scheduler side
    modport slave (
        input  btn_a, btn_b, ra, ga, rb, gb,
        output req_a, req_b, pending_a, pending_b, walk_a, walk_b,
               dwalk_a, dwalk_b, abort_a, abort_b
    );
endinterface
`default_nettype wire

// File: rtl/ped_crossing_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : ped_crossing_scheduler
// Brief    : Debounces crosswalk buttons, gates walk requests to the light
//            controller and drives WALK / flashing DON'T-WALK lamps.
// Revision : 1.0 - initial release
// ============================================================================
module ped_crossing_scheduler #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int MIN_GREEN       = 30,
    parameter int WALK_CYCLES     = 40,
    parameter int FLASH_CYCLES    = 20,
    parameter int FLASH_HALF      = 4
) (
    input  wire logic               clk,
    input  wire logic               reset,
    ped_crossing_scheduler_if.slave bus
);

    localparam int c_dw   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int c_gw   = $clog2(MIN_GREEN + 1);
    localparam int c_pmax = (WALK_CYCLES > FLASH_CYCLES) ? WALK_CYCLES : FLASH_CYCLES;
    localparam int c_pw   = $clog2(c_pmax + 1);
    localparam int c_hw   = $clog2(FLASH_HALF + 1);

    localparam logic [c_dw-1:0] c_deb_last   = c_dw'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_gw-1:0] c_gmax       = c_gw'(MIN_GREEN);
    localparam logic [c_pw-1:0] c_walk_last  = c_pw'(WALK_CYCLES - 1);
    localparam logic [c_pw-1:0] c_flash_last = c_pw'(FLASH_CYCLES - 1);
    localparam logic [c_hw-1:0] c_half_last  = c_hw'(FLASH_HALF - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PEND  = 2'd1,
        S_WALK  = 2'd2,
        S_FLASH = 2'd3
    } state_t;

    // Index 0 is crossing A, index 1 is crossing B
    logic [1:0] w_btn;
    logic [1:0] w_own_g;
    logic [1:0] w_own_r;
    logic [1:0] w_cross_g;
    logic [1:0] w_served;
    logic [1:0] w_req;
    logic [1:0] w_pend;
    logic [1:0] w_walk;
    logic [1:0] w_dwalk;
    logic [1:0] w_abort;

    assign w_btn     = {bus.btn_b, bus.btn_a};
    assign w_own_g   = {bus.gb, bus.ga};
    assign w_own_r   = {bus.rb, bus.ra};
    assign w_cross_g = {bus.ga, bus.gb};

    for (genvar i = 0; i < 2; i++) begin : g_cross
        logic            r_sync1;
        logic            r_sync2;
        logic            r_deb;
        logic            r_deb_d;
        logic [c_dw-1:0] r_dcnt;
        logic [c_gw-1:0] r_gcnt;
        logic [c_pw-1:0] r_pcnt;
        logic [c_pw-1:0] w_pcnt_nx;
        logic [c_hw-1:0] r_half;
        logic            r_flash_lvl;
        logic            r_abort;
        logic            w_abort_nx;
        logic            w_press;
        state_t          r_state;
        state_t          w_state_nx;

        // Debounced level moves only after DEBOUNCE_CYCLES stable samples
        always_ff @(posedge clk) begin
            if (reset) begin
                r_sync1 <= 1'b0;
                r_sync2 <= 1'b0;
                r_deb   <= 1'b0;
                r_deb_d <= 1'b0;
                r_dcnt  <= '0;
            end else begin
                r_sync1 <= w_btn[i];
                r_sync2 <= r_sync1;
                r_deb_d <= r_deb;
                if (r_sync2 != r_deb) begin
                    if (r_dcnt == c_deb_last) begin
                        r_deb  <= r_sync2;
                        r_dcnt <= '0;
                    end else begin
                        r_dcnt <= r_dcnt + 1'b1;
                    end
                end else begin
                    r_dcnt <= '0;
                end
            end
        end

        assign w_press = r_deb & ~r_deb_d;

        always_ff @(posedge clk) begin
            if (reset || !w_own_g[i]) begin
                r_gcnt <= '0;
            end else if (r_gcnt != c_gmax) begin
                r_gcnt <= r_gcnt + 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                r_state <= S_IDLE;
                r_pcnt  <= '0;
                r_abort <= 1'b0;
            end else begin
                r_state <= w_state_nx;
                r_pcnt  <= w_pcnt_nx;
                r_abort <= w_abort_nx;
            end
        end

        // Losing the cross-road green takes priority over normal phase expiry
        always_comb begin
            w_state_nx = r_state;
            w_pcnt_nx  = r_pcnt;
            w_abort_nx = 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_press) begin
                        w_state_nx = S_PEND;
                    end
                end
                S_PEND: begin
                    if (w_own_r[i] && w_cross_g[i]) begin
                        w_state_nx = S_WALK;
                        w_pcnt_nx  = '0;
                    end
                end
                S_WALK: begin
                    if (!w_cross_g[i]) begin
                        w_state_nx = S_IDLE;
                        w_pcnt_nx  = '0;
                        w_abort_nx = 1'b1;
                    end else if (r_pcnt == c_walk_last) begin
                        w_state_nx = S_FLASH;
                        w_pcnt_nx  = '0;
                    end else begin
                        w_pcnt_nx = r_pcnt + 1'b1;
                    end
                end
                S_FLASH: begin
                    if (!w_cross_g[i]) begin
                        w_state_nx = S_IDLE;
                        w_pcnt_nx  = '0;
                        w_abort_nx = 1'b1;
                    end else if (r_pcnt == c_flash_last) begin
                        w_state_nx = S_IDLE;
                        w_pcnt_nx  = '0;
                    end else begin
                        w_pcnt_nx = r_pcnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nx = S_IDLE;
                    w_pcnt_nx  = '0;
                end
            endcase
        end

        // Clearance flash always opens with the lamp lit
        always_ff @(posedge clk) begin
            if (reset) begin
                r_half      <= '0;
                r_flash_lvl <= 1'b1;
            end else if (r_state != S_FLASH && w_state_nx == S_FLASH) begin
                r_half      <= '0;
                r_flash_lvl <= 1'b1;
            end else if (r_state == S_FLASH) begin
                if (r_half == c_half_last) begin
                    r_half      <= '0;
                    r_flash_lvl <= ~r_flash_lvl;
                end else begin
                    r_half <= r_half + 1'b1;
                end
            end
        end

        assign w_served[i] = (r_state == S_WALK) || (r_state == S_FLASH);
        assign w_pend[i]   = (r_state == S_PEND);
        assign w_walk[i]   = (r_state == S_WALK);
        assign w_dwalk[i]  = (r_state == S_FLASH) ? r_flash_lvl : (r_state != S_WALK);
        assign w_abort[i]  = r_abort;

        // Interlock: never ask to end a green that is serving the other walk
        assign w_req[i] = w_pend[i] && w_own_g[i] && (r_gcnt == c_gmax) && !w_served[1-i];
    end

    assign bus.req_a     = w_req[0];
    assign bus.req_b     = w_req[1];
    assign bus.pending_a = w_pend[0];
    assign bus.pending_b = w_pend[1];
    assign bus.walk_a    = w_walk[0];
    assign bus.walk_b    = w_walk[1];
    assign bus.dwalk_a   = w_dwalk[0];
    assign bus.dwalk_b   = w_dwalk[1];
    assign bus.abort_a   = w_abort[0];
    assign bus.abort_b   = w_abort[1];

endmodule
`default_nettype wire

// File: doc/ped_crossing_scheduler.md
Name:
ped_crossing_scheduler

Overview:
Pedestrian-crossing scheduler that sits between the raw crosswalk push-buttons and the two-road traffic light controller. It synchronises and debounces the buttons, latches pending requests, and raises the controller's walk-request inputs (Sa/Sb) only after a minimum green time and only when no opposing walk is in progress. It also drives the WALK / DON'T-WALK pedestrian lamps, with a flashing clearance interval, for each crossing.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable synchronised samples required to accept a button level change
MIN_GREEN, 30, cycles the served road's green must have been on before its request is raised
WALK_CYCLES, 40, cycles of steady WALK
FLASH_CYCLES, 20, cycles of flashing DON'T-WALK clearance
FLASH_HALF, 4, half-period of the clearance flash, in cycles

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
btn_a  in  1  raw asynchronous button, pedestrian crossing road A
btn_b  in  1  raw asynchronous button, pedestrian crossing road B
ra, ga  in  1 each  road A red/green from the light controller
rb, gb  in  1 each  road B red/green from the light controller
req_a  out  1  level request to end A green; drives controller Sa
req_b  out  1  level request to end B green; drives controller Sb
pending_a, pending_b  out  1 each  "request registered" indicator lamps
walk_a, walk_b  out  1 each  WALK lamp
dwalk_a, dwalk_b  out  1 each  DON'T-WALK lamp
abort_a, abort_b  out  1 each  one-cycle pulse: walk cut short by loss of cross-road green

Behaviour:
- Crossings A and B use identical, symmetric logic. A is described below; B is A with a<->b swapped.
- Crossing A walks while road A is red and road B is green (ra && gb).
- Reset values: all FSMs IDLE, counters 0, debounced levels 0. req=0, pending=0, walk=0, dwalk=1, abort=0. Reset mid-walk forces IDLE on the next edge.
- Button input path: a 2-FF synchroniser feeds a stable counter.
  - The counter increments while the synchronised level differs from the debounced level, and clears otherwise.
  - When the count reaches DEBOUNCE_CYCLES, the debounced level takes the new value.
  - A rising edge of the debounced level is a "press".
  - For a clean press first sampled high at edge k, pending_a=1 after edge k+DEBOUNCE_CYCLES+2.
  - Glitches shorter than DEBOUNCE_CYCLES produce no press.
- Green counter gcnt_a: increments while ga=1, saturates at MIN_GREEN, and clears to 0 on any cycle with ga=0.
- FSM per crossing, states IDLE, PEND, WALK, FLASH:
  - IDLE: press -> PEND.
  - PEND: ra && gb sampled -> WALK, and the phase counter loads 0. Further presses are ignored.
  - WALK: counter reaches WALK_CYCLES-1 -> FLASH with the counter reloaded to 0. If gb=0 -> IDLE with abort_a=1 for one cycle.
  - FLASH: counter reaches FLASH_CYCLES-1 -> IDLE. If gb=0 -> IDLE with abort_a=1.
  - Presses during WALK/FLASH are ignored; the crossing is considered served.
- Outputs (registered, from state):
  - pending_a=1 in PEND.
  - walk_a=1 only in WALK.
  - dwalk_a=1 in IDLE/PEND, 0 in WALK. In FLASH it starts at 1 and toggles every FLASH_HALF cycles.
- req_a = (state_a==PEND) && ga && (gcnt_a==MIN_GREEN) && (state_b not WALK/FLASH).
  - This is an interlock: the green serving a walk in progress is never cut short by a request.
  - req_a is combinational from registered values. It drops when ga falls, and the controller sees at least one cycle of high.
- Simultaneous presses on A and B: both go PEND. The crossing whose walk condition holds first walks first; the other request is held until that walk ends.
- A press on the same edge as a reset is discarded.
- walk_a and walk_b are never both 1. Bench assertion: walk_x=1 implies the matching cross-road green.

Test Plan:
- Reset, then idle 200 cycles -> all req/pending/walk=0, dwalk=1, abort=0.
- btn_a glitch high for 3 cycles -> no pending_a. btn_a held high from edge k -> pending_a=1 after edge k+6.
- pending_a with ga rising at edge g -> req_a=1 only from cycle g+30. The controller then reaches B green -> walk_a=1 for 40 cycles, then dwalk_a flashes 1,0,1,0,1 in 4-cycle halves over 20 cycles, then IDLE, dwalk_a=1.
- During walk_b (A green), btn_a pressed -> req_a stays 0 until walk_b/flash_b completes. It then asserts, provided ga was on for at least 30 cycles.
- gb forced low 10 cycles into walk_a -> walk_a=0 and abort_a=1 for exactly one cycle on the next edge, then FSM IDLE.
- reset asserted mid-FLASH -> next edge: IDLE, dwalk_a=1, pending_a=0, req_a=0. A subsequent press behaves as a fresh request.
